mem_stage: RTL and testbench

MEM stage of the 5-stage MIPS pipeline, sitting between EX/MEM and MEM/WB. Decodes the EX/MEM ALU result as a byte address and serves loads and stores to on-chip data RAM or memory-mapped peripherals: timer with interrupt, LEDs, switches, 7-segment driver and system tick counter. Read data is combinational within the cycle, and MEM/WB registers it as the memory-output operand. Timer interrupt is delivered to the control/PC logic.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/mem_stage_if.sv | 13 +
 rtl/mem_stage_timer.sv | 51 +++++
 rtl/mem_stage.sv | 101 ++++++++++
 tb/tb_mem_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and peripheral address decode for the MIPS MEM stage.
`default_nettype none
package mips_pkg;

  localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'h4000_0000;

  localparam logic [31:0] TH_OFF      = 32'h00;
  localparam logic [31:0] TL_OFF      = 32'h04;
  localparam logic [31:0] TCON_OFF    = 32'h08;
  localparam logic [31:0] LED_OFF     = 32'h0C;
  localparam logic [31:0] SW_OFF      = 32'h10;
  localparam logic [31:0] DIGI_OFF    = 32'h14;
  localparam logic [31:0] SYSTICK_OFF = 32'h18;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  typedef enum logic [2:0] {
    REG_NONE, REG_TH, REG_TL, REG_TCON, REG_LED, REG_SW, REG_DIGI, REG_TICK
  } preg_e;

  // Byte-lane bits cannot disturb off[31:2] because the base is word aligned.
  function automatic preg_e periph_decode(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    case (off[31:2])
      TH_OFF[31:2]:      return REG_TH;
      TL_OFF[31:2]:      return REG_TL;
      TCON_OFF[31:2]:    return REG_TCON;
      LED_OFF[31:2]:     return REG_LED;
      SW_OFF[31:2]:      return REG_SW;
      DIGI_OFF[31:2]:    return REG_DIGI;
      SYSTICK_OFF[31:2]: return REG_TICK;
      default:           return REG_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
// mem_stage_if: load/store bus between the EX/MEM register and the MEM stage.
`default_nettype none
interface mem_stage_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output mem_read, mem_write, addr, wdata, input rdata);
  modport slave  (input mem_read, mem_write, addr, wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/mem_stage_timer.sv
// mem_timer: TH/TL/TCON reload timer with level interrupt.
`default_nettype none
module mem_timer
  import mips_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        i_we_th,
  input  wire logic        i_we_tl,
  input  wire logic        i_we_tcon,
  input  wire logic [31:0] i_wdata,
  output logic      [31:0] o_th,
  output logic      [31:0] o_tl,
  output logic      [2:0]  o_tcon,
  output logic             o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_wrap;

  assign w_wrap = (r_tl == 32'hFFFF_FFFF);

  // CPU writes take priority over count/reload; reload samples the pre-write TH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (i_we_th)
        r_th <= i_wdata;
      if (i_we_tl)
        r_tl <= i_wdata;
      else if (r_tcon[TCON_EN])
        r_tl <= w_wrap ? r_th : r_tl + 32'd1;
      if (i_we_tcon)
        r_tcon <= i_wdata[2:0];
      else if (r_tcon[TCON_EN] && w_wrap && r_tcon[TCON_IE])
        r_tcon[TCON_ST] <= 1'b1;
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IE] & r_tcon[TCON_ST];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage serving loads/stores to data RAM and memory-mapped peripherals.
`default_nettype none
module mem_stage
  import mips_pkg::*;
#(
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mem_stage_if.slave       bus,
  input  wire logic [7:0]  switch_in,
  output logic      [7:0]  led,
  output logic      [11:0] digi,
  output logic             irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] r_ram [RAM_WORDS];
  logic [7:0]  r_led;
  logic [11:0] r_digi;
  logic [31:0] r_tick;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;

  logic          w_ram_sel;
  logic [AW-1:0] w_idx;
  preg_e         w_reg;
  logic          w_we_periph;
  logic [31:0]   w_th;
  logic [31:0]   w_tl;
  logic [2:0]    w_tcon;

  assign w_ram_sel   = (bus.addr < 32'(4 * RAM_WORDS));
  assign w_idx       = bus.addr[AW+1:2];
  assign w_reg       = periph_decode(bus.addr, PERIPH_BASE);
  assign w_we_periph = bus.mem_write & ~w_ram_sel;

  always_ff @(posedge clk) begin
    if (bus.mem_write && w_ram_sel)
      r_ram[w_idx] <= bus.wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led     <= '0;
      r_digi    <= '0;
      r_tick    <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_tick    <= r_tick + 32'd1;
      r_sw_meta <= switch_in;
      r_sw_sync <= r_sw_meta;
      if (w_we_periph && w_reg == REG_LED)
        r_led <= bus.wdata[7:0];
      if (w_we_periph && w_reg == REG_DIGI)
        r_digi <= bus.wdata[11:0];
    end
  end

  mem_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_we_th   (w_we_periph && w_reg == REG_TH),
    .i_we_tl   (w_we_periph && w_reg == REG_TL),
    .i_we_tcon (w_we_periph && w_reg == REG_TCON),
    .i_wdata   (bus.wdata),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon),
    .o_irq     (irq)
  );

  // Read mux shows pre-edge state, so a read+write in one cycle returns the old value.
  always_comb begin
    bus.rdata = '0;
    if (bus.mem_read) begin
      if (w_ram_sel) begin
        bus.rdata = r_ram[w_idx];
      end else begin
        case (w_reg)
          REG_TH:   bus.rdata = w_th;
          REG_TL:   bus.rdata = w_tl;
          REG_TCON: bus.rdata = {29'd0, w_tcon};
          REG_LED:  bus.rdata = {24'd0, r_led};
          REG_SW:   bus.rdata = {24'd0, r_sw_sync};
          REG_DIGI: bus.rdata = {20'd0, r_digi};
          REG_TICK: bus.rdata = r_tick;
          default:  bus.rdata = '0;
        endcase
      end
    end
  end

  assign led  = r_led;
  assign digi = r_digi;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a behavioural memory-map model.
`default_nettype none
module tb_mem_stage;

  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] PB        = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  switch_in = 8'h00;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  always #10 clk = ~clk;

  mem_stage_if bus_if ();

  mem_stage #(.RAM_WORDS(RAM_WORDS), .PERIPH_BASE(PB)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .switch_in (switch_in),
    .led       (led),
    .digi      (digi),
    .irq       (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  logic [31:0] m_ram [int];
  int          ram_keys [$];
  logic [31:0] m_th, m_tl, m_tick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led, m_sw1, m_sw2;
  logic [11:0] m_digi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_tcon = 0; m_tick = 0;
    m_led = 0; m_digi = 0; m_sw1 = 0; m_sw2 = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    int idx;
    if (a < 32'(4 * RAM_WORDS)) begin
      idx = int'(a >> 2);
      return m_ram.exists(idx) ? m_ram[idx] : 32'h0;
    end
    w = {a[31:2], 2'b00};
    case (w)
      PB + 32'h00: return m_th;
      PB + 32'h04: return m_tl;
      PB + 32'h08: return {29'd0, m_tcon};
      PB + 32'h0C: return {24'd0, m_led};
      PB + 32'h10: return {24'd0, m_sw2};
      PB + 32'h14: return {20'd0, m_digi};
      PB + 32'h18: return m_tick;
      default:     return 32'h0;
    endcase
  endfunction

  // One clock edge of the memory map: timer rules first, then any CPU store overrides.
  task automatic model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] tl_n, w;
    logic [2:0]  tcon_n;
    int idx;
    tl_n = m_tl;
    tcon_n = m_tcon;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        tl_n = m_th;
        if (m_tcon[1]) tcon_n[2] = 1'b1;
      end else begin
        tl_n = m_tl + 1;
      end
    end
    m_tick = m_tick + 1;
    m_sw2 = m_sw1;
    m_sw1 = switch_in;
    if (wr) begin
      w = {a[31:2], 2'b00};
      if (a < 32'(4 * RAM_WORDS)) begin
        idx = int'(a >> 2);
        if (!m_ram.exists(idx)) ram_keys.push_back(idx);
        m_ram[idx] = d;
      end else if (w == PB + 32'h00) m_th = d;
      else if (w == PB + 32'h04) tl_n = d;
      else if (w == PB + 32'h08) tcon_n = d[2:0];
      else if (w == PB + 32'h0C) m_led = d[7:0];
      else if (w == PB + 32'h14) m_digi = d[11:0];
    end
    m_tl = tl_n;
    m_tcon = tcon_n;
  endtask

  // Entered just after a posedge (or during reset release); returns 1 time unit after the next posedge.
  task automatic cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus_if.mem_read  = rd;
    bus_if.mem_write = wr;
    bus_if.addr      = a;
    bus_if.wdata     = d;
    if (rd) exp_q.push_back(model_read(a));
    @(posedge clk);
    model_edge(wr, a, d);
    #1;
    bus_if.mem_read  = 1'b0;
    bus_if.mem_write = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.mem_read) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rdata: read with no expected entry, got %h", bus_if.rdata);
        end else begin
          check("rdata", bus_if.rdata, exp_q.pop_front());
        end
      end
      check("irq", {31'd0, irq}, {31'd0, m_tcon[1] & m_tcon[2]});
      check("led", {24'd0, led}, {24'd0, m_led});
      check("digi", {20'd0, digi}, {20'd0, m_digi});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic rd, wr;
    int r, idx;
    bus_if.mem_read = 0; bus_if.mem_write = 0; bus_if.addr = 0; bus_if.wdata = 0;
    model_reset();
    #2;
    check("reset led", {24'd0, led}, 32'h0);
    check("reset digi", {20'd0, digi}, 32'h0);
    check("reset irq", {31'd0, irq}, 32'h0);
    check("reset rdata idle", bus_if.rdata, 32'h0);
    #3 reset = 1'b0;

    // RAM round trip and unmapped read
    cycle(0, 1, 32'h10, 32'hDEAD_BEEF);
    cycle(1, 0, 32'h10, 0);
    cycle(1, 0, 32'h13, 0);
    cycle(1, 0, 32'h400, 0);
    // Same-cycle read/write
    cycle(0, 1, 32'h10, 32'h1);
    cycle(1, 1, 32'h10, 32'h2);
    cycle(1, 0, 32'h10, 0);
    // Timer reload and irq
    cycle(0, 1, PB + 32'h00, 32'hFFFF_FFFD);
    cycle(0, 1, PB + 32'h04, 32'hFFFF_FFFE);
    cycle(0, 1, PB + 32'h08, 32'h3);
    cycle(1, 0, PB + 32'h04, 0);
    cycle(1, 0, PB + 32'h04, 0);
    cycle(1, 0, PB + 32'h08, 0);
    cycle(0, 1, PB + 32'h08, 32'h3);
    cycle(1, 0, PB + 32'h08, 0);
    // Write beats increment
    cycle(0, 1, PB + 32'h04, 32'h5);
    cycle(1, 0, PB + 32'h04, 0);
    cycle(1, 0, PB + 32'h04, 0);
    // Peripherals
    cycle(0, 1, PB + 32'h0C, 32'hA5);
    cycle(0, 1, PB + 32'h14, 32'hF3F);
    switch_in = 8'h3C;
    for (int i = 0; i < 4; i++) cycle(1, 0, PB + 32'h10, 0);
    cycle(1, 1, PB + 32'h18, 32'h1234_5678);
    cycle(1, 0, PB + 32'h18, 0);

    // Asynchronous reset between edges while the timer is about to raise irq
    cycle(0, 1, PB + 32'h0C, 32'hFF);
    cycle(0, 1, PB + 32'h04, 32'hFFFF_FFFF);
    cycle(1, 0, PB + 32'h08, 0);
    cycle(1, 0, PB + 32'h04, 0);
    #1 reset = 1'b1;
    #1;
    check("async led", {24'd0, led}, 32'h0);
    check("async irq", {31'd0, irq}, 32'h0);
    bus_if.mem_read = 1; bus_if.addr = PB + 32'h04;
    #1 check("async TL", bus_if.rdata, 32'h0);
    bus_if.addr = PB + 32'h08;
    #1 check("async TCON", bus_if.rdata, 32'h0);
    bus_if.mem_read = 0;
    #1 reset = 1'b0;
    model_reset();
    cycle(1, 0, PB + 32'h18, 0);
    cycle(1, 0, PB + 32'h18, 0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) switch_in = 8'($urandom);
      r = $urandom_range(0, 9);
      d = $urandom;
      rd = 0; wr = 0;
      if (r <= 1 || (r <= 3 && ram_keys.size() == 0)) begin
        idx = $urandom_range(0, RAM_WORDS - 1);
        a = 32'(idx * 4) + 32'($urandom_range(0, 3));
        wr = 1;
      end else if (r <= 3) begin
        idx = ram_keys[$urandom_range(0, ram_keys.size() - 1)];
        a = 32'(idx * 4) + 32'($urandom_range(0, 3));
        rd = 1;
        wr = (r == 3);
      end else if (r == 4) begin
        case ($urandom_range(0, 3))
          0: a = $urandom_range(32'h400, 32'h3FFF_FFFF);
          1: a = PB + 32'h1C + 32'($urandom_range(0, 3));
          2: a = PB + 32'h20 + 32'($urandom_range(0, 255));
          default: a = 32'h8000_0000 | 32'($urandom);
        endcase
        rd = 1;
        wr = 1'($urandom);
      end else begin
        a = PB + 32'($urandom_range(0, 6) * 4) + 32'($urandom_range(0, 3));
        if ({a[31:2], 2'b00} == PB + 32'h04 && $urandom_range(0, 1) == 1)
          d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        rd = 1'($urandom);
        wr = !rd || ($urandom_range(0, 3) == 0);
      end
      cycle(rd, wr, a, d);
    end

    cycle(0, 0, 32'h0, 32'h0);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
